// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic-light safety monitor.
//   - Light encoding {red,yellow,green}, fault cause codes, approach indices.
//   - Monitor FSM state type.
//   - Helpers: one-hot legality test and lowest-set-index encoder.
package traffic_pkg;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    localparam logic [2:0] FLT_NONE      = 3'd0;
    localparam logic [2:0] FLT_ENC       = 3'd1;
    localparam logic [2:0] FLT_CONFLICT  = 3'd2;
    localparam logic [2:0] FLT_SEQ       = 3'd3;
    localparam logic [2:0] FLT_SHORT_YEL = 3'd4;
    localparam logic [2:0] FLT_STARVE    = 3'd5;

    localparam logic [1:0] DIR_A = 2'd0;
    localparam logic [1:0] DIR_B = 2'd1;
    localparam logic [1:0] DIR_C = 2'd2;
    localparam logic [1:0] DIR_D = 2'd3;

    typedef enum logic [1:0] {
        MON_ARM   = 2'd0,
        MON_RUN   = 2'd1,
        MON_FAULT = 2'd2
    } mon_state_e;

    function automatic logic is_legal(input logic [2:0] v);
        return (v == LT_RED) || (v == LT_YEL) || (v == LT_GRN);
    endfunction

    // Index of the lowest set bit; DIR_A when none is set.
    function automatic logic [1:0] first_set(input logic [3:0] v);
        logic [1:0] r;
        r = DIR_A;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/traffic_monitor_tracker.sv
// light_tracker: per-approach history for the traffic monitor.
//   clk, rst_n   : clock, asynchronous active-low reset
//   light        : this approach's {red,yellow,green} bus
//   checking     : high while the monitor is in its checking state
//   e_enc        : value on light is not one-hot
//   e_seq        : light changed along an illegal edge
//   e_short      : yellow->red with yellow held fewer than MIN_YELLOW cycles
//   e_starve     : red dwell reaches MAX_RED+1 on this edge
//   serviced     : registered one-cycle pulse on a good yellow->red
// The e_* flags are combinational on the current input and the stored
// history, so the top can register its verdict on the same edge.
module light_tracker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_RED    = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] light,
    input  logic       checking,
    output logic       e_enc,
    output logic       e_seq,
    output logic       e_short,
    output logic       e_starve,
    output logic       serviced
);

    localparam int DW = $clog2(MAX_RED + 2);
    localparam logic [DW-1:0] DWELL_SAT = DW'(MAX_RED + 1);

    logic [2:0]    prev;
    logic [DW-1:0] dwell;
    logic [DW-1:0] dwell_next;
    logic          changed;
    logic          legal_step;
    logic          yel_to_red;

    always_comb begin
        changed    = (light != prev);
        legal_step = ((prev == LT_GRN) && (light == LT_YEL)) ||
                     ((prev == LT_YEL) && (light == LT_RED)) ||
                     ((prev == LT_RED) && (light == LT_GRN));
        yel_to_red = (prev == LT_YEL) && (light == LT_RED);
        e_enc      = !is_legal(light);
        e_seq      = changed && !legal_step;
        // dwell holds how many edges the previous value was sampled.
        e_short    = yel_to_red && (dwell < DW'(MIN_YELLOW));
        e_starve   = (light == LT_RED) && !changed && (dwell == DW'(MAX_RED));
        if (changed) begin
            dwell_next = DW'(1);
        end else if (dwell == DWELL_SAT) begin
            dwell_next = dwell;
        end else begin
            dwell_next = dwell + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= LT_RED;
            dwell    <= '0;
            serviced <= 1'b0;
        end else begin
            prev     <= light;
            dwell    <= dwell_next;
            serviced <= checking && yel_to_red && !e_short;
        end
    end

endmodule

// File: rtl/traffic_monitor.sv
// traffic_monitor: passive safety monitor on the four approach-light buses.
//   clk, rst_n  : clock, asynchronous active-low reset
//   A, B, C, D  : approach lights {red,yellow,green}
//   clr_fault   : single-cycle fault clear (honoured only in FAULT)
//   armed       : high while checking
//   fault       : sticky fault flag
//   fault_code  : first fault cause, fault_dir: its approach
//   fault_cnt   : saturating count of FAULT entries
//   serviced    : per-approach pulse on a completed yellow->red
//   state_dbg   : current monitor state
// The verdict for the value sampled at an edge is registered at that edge.
module traffic_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_RED    = 64,
    parameter int ARM_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] A,
    input  logic [2:0] B,
    input  logic [2:0] C,
    input  logic [2:0] D,
    input  logic       clr_fault,
    output logic       armed,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir,
    output logic [7:0] fault_cnt,
    output logic [3:0] serviced,
    output mon_state_e state_dbg
);

    localparam int AW = $clog2(ARM_CYCLES + 1);

    logic [3:0][2:0] lights;
    logic [3:0]      enc, seq, shrt, starve, nonred;
    logic            conflict, clean, viol;
    logic [2:0]      v_code;
    logic [1:0]      v_dir;

    mon_state_e      state, state_next;
    logic [AW-1:0]   arm_cnt, arm_next;
    logic [2:0]      code_next;
    logic [1:0]      dir_next;
    logic [7:0]      cnt_next;

    assign lights = {D, C, B, A};

    for (genvar g = 0; g < 4; g++) begin : g_trk
        light_tracker #(
            .MIN_YELLOW(MIN_YELLOW),
            .MAX_RED   (MAX_RED)
        ) u_trk (
            .clk     (clk),
            .rst_n   (rst_n),
            .light   (lights[g]),
            .checking(state == MON_RUN),
            .e_enc   (enc[g]),
            .e_seq   (seq[g]),
            .e_short (shrt[g]),
            .e_starve(starve[g]),
            .serviced(serviced[g])
        );
        assign nonred[g] = (lights[g] != LT_RED);
    end

    // Cause priority: lowest code first, then lowest approach index.
    always_comb begin
        conflict = ($countones(nonred) > 1);
        clean    = !(|enc) && !conflict;
        viol     = 1'b1;
        v_code   = FLT_NONE;
        v_dir    = DIR_A;
        if (|enc) begin
            v_code = FLT_ENC;
            v_dir  = first_set(enc);
        end else if (conflict) begin
            v_code = FLT_CONFLICT;
            v_dir  = first_set(nonred);
        end else if (|seq) begin
            v_code = FLT_SEQ;
            v_dir  = first_set(seq);
        end else if (|shrt) begin
            v_code = FLT_SHORT_YEL;
            v_dir  = first_set(shrt);
        end else if (|starve) begin
            v_code = FLT_STARVE;
            v_dir  = first_set(starve);
        end else begin
            viol = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        arm_next   = arm_cnt;
        code_next  = fault_code;
        dir_next   = fault_dir;
        cnt_next   = fault_cnt;
        case (state)
            MON_ARM: begin
                if (clean) begin
                    arm_next = arm_cnt + AW'(1);
                    if (arm_next == AW'(ARM_CYCLES)) state_next = MON_RUN;
                end else begin
                    arm_next = '0;
                end
            end
            MON_RUN: begin
                if (viol) begin
                    state_next = MON_FAULT;
                    code_next  = v_code;
                    dir_next   = v_dir;
                    if (fault_cnt != 8'hFF) cnt_next = fault_cnt + 8'd1;
                end
            end
            MON_FAULT: begin
                if (clr_fault) begin
                    state_next = MON_ARM;
                    arm_next   = '0;
                    code_next  = FLT_NONE;
                    dir_next   = DIR_A;
                end
            end
            default: state_next = MON_ARM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MON_ARM;
            arm_cnt    <= '0;
            fault_code <= FLT_NONE;
            fault_dir  <= DIR_A;
            fault_cnt  <= '0;
        end else begin
            state      <= state_next;
            arm_cnt    <= arm_next;
            fault_code <= code_next;
            fault_dir  <= dir_next;
            fault_cnt  <= cnt_next;
        end
    end

    assign armed     = (state == MON_RUN);
    assign fault     = (state == MON_FAULT);
    assign state_dbg = state;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor. Each driven edge pushes its expected
// outputs (value plus compare mask) into exp_q; a monitor process pops one
// entry after every rising edge and compares.
module tb_traffic_monitor;
    import traffic_pkg::*;

    localparam int OW = 19;
    localparam int W  = 2 * OW;
    localparam logic [OW-1:0] M_ARMED = 19'h40000;
    localparam logic [OW-1:0] M_FAULT = 19'h20000;
    localparam logic [OW-1:0] M_CODE  = 19'h1C000;
    localparam logic [OW-1:0] M_SERV  = 19'h0000F;
    localparam logic [OW-1:0] M_ALL   = 19'h7FFFF;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] a, b, c, d;
    logic       clr;
    logic       armed, fault;
    logic [2:0] fault_code;
    logic [1:0] fault_dir;
    logic [7:0] fault_cnt;
    logic [3:0] serviced;
    mon_state_e state_dbg;

    always #5 clk = ~clk;

    traffic_monitor dut (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d),
        .clr_fault(clr), .armed(armed), .fault(fault),
        .fault_code(fault_code), .fault_dir(fault_dir),
        .fault_cnt(fault_cnt), .serviced(serviced), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           fails  = 0;
    logic         integ_on = 1'b0;
    logic [3:0]   serv_seen = '0;

    function automatic logic [OW-1:0] pk(input logic ar, input logic fl,
                                         input logic [2:0] cd, input logic [1:0] dr,
                                         input logic [7:0] cn, input logic [3:0] sv);
        return {ar, fl, cd, dr, cn, sv};
    endfunction

    function automatic logic [OW-1:0] act_vec();
        return {armed, fault, fault_code, fault_dir, fault_cnt, serviced};
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge + 1; drives the value for the next rising edge.
    task automatic step(input logic [2:0] av, input logic [2:0] bv,
                        input logic [2:0] cv, input logic [2:0] dv,
                        input logic clr_v, input logic [OW-1:0] mask,
                        input logic [OW-1:0] val, input string nm);
        a = av; b = bv; c = cv; d = dv; clr = clr_v;
        exp_q.push_back({mask, val});
        name_q.push_back(nm);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a = R; b = R; c = R; d = R; clr = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0]  e;
        logic [OW-1:0] m, v, x;
        string         nm;
        forever begin
            @(posedge clk);
            #2;
            if (integ_on) serv_seen = serv_seen | serviced;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                m  = e[W-1:OW];
                v  = e[OW-1:0];
                x  = act_vec();
                if (m != '0) begin
                    checks++;
                    if ((x & m) != (v & m)) begin
                        fails++;
                        $display("FAIL %s: got arm/flt/code/dir/cnt/serv=%b/%b/%0d/%0d/%0d/%b expected %b/%b/%0d/%0d/%0d/%b mask=%h",
                                 nm, x[18], x[17], x[16:14], x[13:12], x[11:4], x[3:0],
                                 v[18], v[17], v[16:14], v[13:12], v[11:4], v[3:0], m);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] lt [4];
        int         p;
        do_reset();

        // Normal cycle, A then B; armed rises on the 4th clean edge.
        for (int i = 1; i <= 10; i++)
            step(G, R, R, R, 0, M_ARMED | M_FAULT, pk(i >= 4, 0, 0, 0, 0, 0), "arm_rise");
        for (int i = 0; i < 3; i++)
            step(Y, R, R, R, 0, M_SERV | M_FAULT, pk(1, 0, 0, 0, 0, 0), "a_yellow");
        step(R, R, R, R, 0, M_ALL, pk(1, 0, 0, 0, 0, 4'b0001), "a_serviced");
        for (int i = 0; i < 10; i++)
            step(R, G, R, R, 0, M_SERV | M_FAULT, pk(1, 0, 0, 0, 0, 0), "b_green");
        for (int i = 0; i < 3; i++)
            step(R, Y, R, R, 0, M_FAULT, pk(1, 0, 0, 0, 0, 0), "b_yellow");
        step(R, R, R, R, 0, M_ALL, pk(1, 0, 0, 0, 0, 4'b0010), "b_serviced");

        // Conflict, stickiness, clear.
        step(G, R, R, R, 0, M_ALL, pk(1, 0, 0, 0, 0, 0), "a_green2");
        step(G, R, G, R, 0, M_ALL, pk(0, 1, 2, 0, 1, 0), "conflict");
        step(R, 3'b111, R, R, 0, M_ALL, pk(0, 1, 2, 0, 1, 0), "fault_sticky");
        step(R, R, R, R, 1, M_ALL, pk(0, 0, 0, 0, 1, 0), "clr_fault");
        for (int i = 0; i < 3; i++)
            step(R, R, R, R, 0, M_ARMED, pk(0, 0, 0, 0, 0, 0), "rearm_pre");
        step(3'b000, R, R, R, 0, M_ALL, pk(0, 0, 0, 0, 1, 0), "arm_glitch");
        for (int i = 0; i < 3; i++)
            step(R, R, R, R, 0, M_ARMED, pk(0, 0, 0, 0, 0, 0), "rearm_restart");
        step(R, R, R, R, 0, M_ALL, pk(1, 0, 0, 0, 1, 0), "rearm_done");

        // Asynchronous reset while monitoring.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (act_vec() != '0) begin
            fails++;
            $display("FAIL async_reset: got outputs=%h expected 0", act_vec());
        end
        do_reset();

        // Short yellow, then illegal green->red after re-arming.
        for (int i = 0; i < 5; i++)
            step(G, R, R, R, 0, M_FAULT, pk(0, 0, 0, 0, 0, 0), "sy_green");
        for (int i = 0; i < 2; i++)
            step(Y, R, R, R, 0, M_FAULT, pk(0, 0, 0, 0, 0, 0), "sy_yellow");
        step(R, R, R, R, 0, M_ALL, pk(0, 1, 4, 0, 1, 0), "short_yellow");
        step(R, R, R, R, 1, M_ALL, pk(0, 0, 0, 0, 1, 0), "clr_after_short");
        for (int i = 1; i <= 4; i++)
            step(R, R, R, R, 0, M_ARMED, pk(i == 4, 0, 0, 0, 0, 0), "rearm2");
        step(R, G, R, R, 0, M_ALL, pk(1, 0, 0, 0, 1, 0), "b_green_ok");
        step(R, G, R, R, 1, M_ALL, pk(1, 0, 0, 0, 1, 0), "clr_ignored_run");
        step(R, R, R, R, 0, M_ALL, pk(0, 1, 3, 1, 2, 0), "seq_fault");

        // Starvation boundary: dwell 64 is fine, 65 faults.
        do_reset();
        for (int i = 1; i <= 64; i++)
            step(R, R, R, R, 0, (i == 64) ? M_ALL : M_FAULT, pk(i >= 4, 0, 0, 0, 0, 0), "red_64");
        step(R, R, R, R, 0, M_ALL, pk(0, 1, 5, 0, 1, 0), "starvation");

        // Encoding fault on D beats starvation on the same edge.
        do_reset();
        for (int i = 1; i <= 64; i++)
            step(R, R, R, R, 0, M_FAULT, pk(0, 0, 0, 0, 0, 0), "red_64b");
        step(R, R, R, 3'b011, 0, M_ALL, pk(0, 1, 1, 3, 1, 0), "enc_over_starve");

        // Integration: round-robin controller, 10 green + 3 yellow each.
        do_reset();
        serv_seen = '0;
        integ_on  = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            p = n % 52;
            for (int k = 0; k < 4; k++) lt[k] = R;
            lt[p / 13] = ((p % 13) < 10) ? G : Y;
            step(lt[0], lt[1], lt[2], lt[3], 0, M_FAULT | M_CODE, pk(0, 0, 0, 0, 0, 0), "integ_no_fault");
        end
        repeat (2) @(negedge clk);
        integ_on = 1'b0;
        checks++;
        if (serv_seen != 4'hF) begin
            fails++;
            $display("FAIL integ_serviced: got %b expected 1111", serv_seen);
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drained: got %0d entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
